// File: rtl/field_sw_ctrl_pkg.sv
// Shared field attribute constants: hardware and software access types.
package field_sw_ctrl_pkg;

    localparam int HW_RW = 0;
    localparam int HW_RO = 1;
    localparam int HW_WO = 2;
    localparam int HW_NA = 3;

    localparam int SW_RW  = 0;
    localparam int SW_RO  = 1;
    localparam int SW_WO  = 2;
    localparam int SW_W1C = 3;
    localparam int SW_W1S = 4;
    localparam int SW_RC  = 5;
    localparam int SW_RS  = 6;

    function automatic bit sw_type_valid(input int sw_type);
        return (sw_type >= SW_RW) && (sw_type <= SW_RS);
    endfunction

endpackage

// File: rtl/field_sw_ctrl_sw_ctrl.sv
// Combinational software-access evaluation: next field value, read data and
// the swmod/swacc qualifiers for a single access of the configured type.
module sw_ctrl
    import field_sw_ctrl_pkg::*;
#(
    parameter int F_WIDTH = 4,
    parameter int SW_TYPE = SW_RW
) (
    input  logic [F_WIDTH-1:0] field_value,
    input  logic               sw_wr,
    input  logic [F_WIDTH-1:0] sw_wdata,
    input  logic [F_WIDTH-1:0] sw_wmask,
    output logic [F_WIDTH-1:0] sw_next,
    output logic [F_WIDTH-1:0] rd_data,
    output logic               mod,
    output logic               acc
);

    if (!sw_type_valid(SW_TYPE)) begin : g_bad_sw_type
        $fatal(1, "sw_ctrl: unknown SW_TYPE %0d", SW_TYPE);
    end

    always_comb begin
        sw_next = field_value;
        rd_data = '0;
        mod     = 1'b0;
        acc     = 1'b0;
        if (sw_wr) begin
            case (SW_TYPE)
                SW_RW, SW_WO: begin
                    sw_next = (field_value & ~sw_wmask) | (sw_wdata & sw_wmask);
                    mod     = 1'b1;
                end
                SW_W1C: begin
                    sw_next = field_value & ~(sw_wdata & sw_wmask);
                    mod     = 1'b1;
                end
                SW_W1S: begin
                    sw_next = field_value | (sw_wdata & sw_wmask);
                    mod     = 1'b1;
                end
                default: ;
            endcase
        end else begin
            acc     = 1'b1;
            // Read data is the pre-side-effect value; write-only fields read as zero.
            rd_data = (SW_TYPE == SW_WO) ? '0 : field_value;
            case (SW_TYPE)
                SW_RC: begin
                    sw_next = '0;
                    mod     = 1'b1;
                end
                SW_RS: begin
                    sw_next = '1;
                    mod     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/field_sw_ctrl.sv
// Register field with a two-state software access handshake, hardware update
// port and a configurable collision winner.
module field_sw_ctrl
    import field_sw_ctrl_pkg::*;
#(
    parameter int                 F_WIDTH       = 4,
    parameter int                 SW_TYPE       = SW_RW,
    parameter logic [F_WIDTH-1:0] RESET_VAL     = {F_WIDTH{1'b0}},
    parameter int                 SW_PRECEDENCE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_req,
    input  logic               sw_wr,
    input  logic [F_WIDTH-1:0] sw_wdata,
    input  logic [F_WIDTH-1:0] sw_wmask,
    output logic               sw_ack,
    output logic [F_WIDTH-1:0] sw_rdata,
    input  logic [F_WIDTH-1:0] nxt_hw_value,
    input  logic               hw_modify,
    output logic [F_WIDTH-1:0] field_value,
    output logic               swmod,
    output logic               swacc
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               access;
    logic [F_WIDTH-1:0] sw_next;
    logic [F_WIDTH-1:0] rd_data;
    logic               mod;
    logic               acc;
    logic [F_WIDTH-1:0] field_next;

    sw_ctrl #(
        .F_WIDTH (F_WIDTH),
        .SW_TYPE (SW_TYPE)
    ) u_sw_ctrl (
        .field_value (field_value),
        .sw_wr       (sw_wr),
        .sw_wdata    (sw_wdata),
        .sw_wmask    (sw_wmask),
        .sw_next     (sw_next),
        .rd_data     (rd_data),
        .mod         (mod),
        .acc         (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The access executes on the IDLE->RESP edge; requests seen in RESP are ignored.
    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (sw_req) begin
                    state_next = RESP;
                    access     = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Any executing access collides with a hardware strobe; the loser is dropped whole.
    always_comb begin
        field_next = field_value;
        if (access && hw_modify) begin
            field_next = (SW_PRECEDENCE != 0) ? sw_next : nxt_hw_value;
        end else if (access) begin
            field_next = sw_next;
        end else if (hw_modify) begin
            field_next = nxt_hw_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_value <= RESET_VAL;
            sw_rdata    <= '0;
            swmod       <= 1'b0;
            swacc       <= 1'b0;
        end else begin
            field_value <= field_next;
            sw_rdata    <= access ? rd_data : '0;
            swmod       <= access & mod;
            swacc       <= access & acc;
        end
    end

    assign sw_ack = (state == RESP);

endmodule
